branch_predictor_gshare: RTL and testbench
==========================================

BRANCH_PREDICTOR_GSHARE -- requirements
Module: branch_predictor_gshare

Interface
REQ-001 Parameter IDX_BITS, default 6: PHT/BTB index width; 2^IDX_BITS entries each.
REQ-002 Parameter HIST_BITS, default 4: global history register (GHR) width; legal range 1..IDX_BITS.
REQ-003 Parameter TAG_BITS, default 8: BTB tag width.
REQ-004 Parameter MODE, default 1: 0 = bimodal (PC index only), 1 = gshare (PC XOR GHR).
REQ-005 Clocking: one clock, clk_in; reset rst_in is synchronous and active-high.
REQ-006 clk_in  input  1  system clock.
REQ-007 rst_in  input  1  synchronous active-high reset.
REQ-008 rdy_in  input  1  pause; when low all state holds.
REQ-009 query_valid  input  1  lookup request this cycle.
REQ-010 query_pc  input  32  PC to predict.
REQ-011 flush  input  1  discard any in-flight lookup (rollback).
REQ-012 pred_valid  output  1  prediction valid, registered.
REQ-013 pred_taken  output  1  predicted taken.
REQ-014 pred_target  output  32  predicted next PC.
REQ-015 commit_valid  input  1  ROB commit this cycle.
REQ-016 commit_is_branch  input  1  committed instruction is a conditional branch (BType).
REQ-017 commit_pc  input  32  PC of committed branch.
REQ-018 commit_taken  input  1  actual outcome.
REQ-019 commit_target  input  32  actual taken target.
REQ-020 commit_mispredict  input  1  ROB detected misprediction for this branch.
REQ-021 stat_branches  output  32  committed branch count.
REQ-022 stat_mispredicts  output  32  committed misprediction count.

Function
REQ-023 Index base: ib = pc[IDX_BITS+1:2]; tag = pc[TAG_BITS+IDX_BITS+1:IDX_BITS+2].
REQ-024 PHT index: MODE 0 -> ib; MODE 1 -> ib XOR zero-extended GHR; BTB always indexed by ib.
REQ-025 PHT entries: 2-bit saturating counters, 00 strongly-not-taken .. 11 strongly-taken; MSB = taken.
REQ-026 BTB entry: valid bit, TAG_BITS tag, 32-bit target.
REQ-027 Lookup latency exactly 1 cycle: query_valid at cycle N -> pred_valid high at N+1 for one cycle.
REQ-028 Hit = BTB valid AND tag match; pred_taken = hit AND PHT MSB; pred_target = pred_taken ? BTB target : query_pc+4 (32-bit wrap).
REQ-029 Back-to-back queries every cycle supported, one prediction per cycle, no bubbles.
REQ-030 flush at cycle N forces pred_valid low at N+1 regardless of query_valid at N; flush has no effect on PHT, BTB, GHR, statistics.
REQ-031 Update fires when commit_valid AND commit_is_branch AND rdy_in; PHT index uses GHR value before this update.
REQ-032 Counter update: taken -> +1 saturating at 11; not taken -> -1 saturating at 00.
REQ-033 Taken commit writes BTB[ib]: valid=1, tag, commit_target (replaces any prior entry); not-taken leaves BTB unchanged.
REQ-034 GHR shifts left, LSB = commit_taken, on every update; unchanged otherwise.
REQ-035 stat_branches +1 per update; stat_mispredicts +1 when also commit_mispredict; both wrap 0xFFFFFFFF -> 0.
REQ-036 commit_valid with commit_is_branch low: no state change.
REQ-037 Query and update same cycle, same entry: query returns pre-update PHT/BTB contents (read-before-write).
REQ-038 rdy_in low: no lookup, no update, pred_valid holds its value, query/commit inputs ignored.

Reset
REQ-039 rst_in high at a clk_in edge, overriding rdy_in and all inputs: all PHT = 01, all BTB valid = 0, GHR = 0, pred_valid = 0, pred_taken = 0, pred_target = 0, statistics = 0.
REQ-040 Reset mid-operation discards pending lookup; first prediction earliest 1 cycle after a query following reset release.

Verification
REQ-041 After reset, query 0x100 -> next cycle pred_valid=1, pred_taken=0, pred_target=0x104.
REQ-042 MODE 0: commit 0x100 taken, target 0x80, twice; query 0x100 -> pred_taken=1, pred_target=0x80; three not-taken commits -> pred_taken=0.
REQ-043 Single taken commit of 0x200 (counter 01->10), query 0x200 and same-cycle taken commit -> prediction uses pre-update state; counter saturates at 11 after further taken commits.
REQ-044 MODE 1, HIST_BITS=4: commit pattern T,T,N,T from reset -> GHR=4'b1101; next update indexes PHT at ib XOR 4'b1101.
REQ-045 query at N, flush at N -> pred_valid=0 at N+1; rdy_in low 3 cycles during commit -> stat_branches unchanged.
REQ-046 Preload stat_mispredicts to 0xFFFFFFFF via 2^32-1 mispredict commits (or forced) -> one more mispredict -> 0; tag alias 0x100 vs 0x100+2^(IDX_BITS+2) -> miss, pred_target = pc+4.

Source files
------------

// File: rtl/branch_predictor_gshare.sv
// rtl/branch_predictor_gshare.sv - gshare/bimodal branch predictor with BTB and commit-time training
//
// Ports:
//   clk_in, rst_in       clock; synchronous active-high reset
//   rdy_in               pause; when low every register holds
//   query_valid/pc       lookup request; prediction appears one cycle later
//   flush                drop the lookup issued this cycle
//   pred_valid/taken/target  registered prediction
//   commit_*             retired-branch training port
//   stat_branches/mispredicts  committed branch / misprediction counters
module branch_predictor_gshare #(
  parameter int IDX_BITS  = 6,
  parameter int HIST_BITS = 4,
  parameter int TAG_BITS  = 8,
  parameter int MODE      = 1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        query_valid,
  input  logic [31:0] query_pc,
  input  logic        flush,
  output logic        pred_valid,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        commit_valid,
  input  logic        commit_is_branch,
  input  logic [31:0] commit_pc,
  input  logic        commit_taken,
  input  logic [31:0] commit_target,
  input  logic        commit_mispredict,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
);

  localparam int ENTRIES = 1 << IDX_BITS;

  logic [1:0]          pht        [ENTRIES];
  logic                btb_valid  [ENTRIES];
  logic [TAG_BITS-1:0] btb_tag    [ENTRIES];
  logic [31:0]         btb_target [ENTRIES];
  logic [HIST_BITS-1:0] ghr;
  logic [31:0]         stat_br_q;
  logic [31:0]         stat_mis_q;

  logic [IDX_BITS-1:0] ghr_ext;
  logic [IDX_BITS-1:0] q_ib;
  logic [IDX_BITS-1:0] q_pht_idx;
  logic [TAG_BITS-1:0] q_tag;
  logic                q_hit;
  logic                q_taken;
  logic [31:0]         q_target;
  logic                q_issue;

  logic [IDX_BITS-1:0] c_ib;
  logic [IDX_BITS-1:0] c_pht_idx;
  logic [TAG_BITS-1:0] c_tag;
  logic                upd;
  logic                unused_commit_pc;

  // Only the index/tag slice of commit_pc is meaningful here.
  assign unused_commit_pc = ^commit_pc;

  assign ghr_ext = IDX_BITS'(ghr);

  assign q_ib      = query_pc[IDX_BITS+1:2];
  assign q_tag     = query_pc[TAG_BITS+IDX_BITS+1:IDX_BITS+2];
  assign q_pht_idx = (MODE == 0) ? q_ib : (q_ib ^ ghr_ext);

  assign c_ib      = commit_pc[IDX_BITS+1:2];
  assign c_tag     = commit_pc[TAG_BITS+IDX_BITS+1:IDX_BITS+2];
  assign c_pht_idx = (MODE == 0) ? c_ib : (c_ib ^ ghr_ext);

  // Lookup reads array contents as they stand before this edge's update,
  // which gives read-before-write when query and commit hit the same entry.
  assign q_hit    = btb_valid[q_ib] && (btb_tag[q_ib] == q_tag);
  assign q_taken  = q_hit && pht[q_pht_idx][1];
  assign q_target = q_taken ? btb_target[q_ib] : (query_pc + 32'd4);
  assign q_issue  = query_valid && !flush;

  assign upd = commit_valid && commit_is_branch && rdy_in;

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mis_q;

  function automatic logic [1:0] next_ctr(input logic [1:0] ctr, input logic taken);
    logic [1:0] n;
    n = ctr;
    if (taken && ctr != 2'b11) n = ctr + 2'b01;
    else if (!taken && ctr != 2'b00) n = ctr - 2'b01;
    return n;
  endfunction

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < ENTRIES; i++) begin
        pht[i]        <= 2'b01;
        btb_valid[i]  <= 1'b0;
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
      end
      ghr         <= '0;
      pred_valid  <= 1'b0;
      pred_taken  <= 1'b0;
      pred_target <= '0;
      stat_br_q   <= '0;
      stat_mis_q  <= '0;
    end else if (rdy_in) begin
      pred_valid <= q_issue;
      // Taken/target keep their last value while no prediction is issued.
      if (q_issue) begin
        pred_taken  <= q_taken;
        pred_target <= q_target;
      end

      if (upd) begin
        pht[c_pht_idx] <= next_ctr(pht[c_pht_idx], commit_taken);
        if (commit_taken) begin
          btb_valid[c_ib]  <= 1'b1;
          btb_tag[c_ib]    <= c_tag;
          btb_target[c_ib] <= commit_target;
        end
        // Truncating cast drops the oldest bit, so this also works for HIST_BITS == 1.
        ghr       <= HIST_BITS'({ghr, commit_taken});
        stat_br_q <= stat_br_q + 32'd1;
        if (commit_mispredict) stat_mis_q <= stat_mis_q + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// tb/tb_branch_predictor_gshare.sv - self-checking bench for branch_predictor_gshare
module tb_branch_predictor_gshare;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, query_valid, flush;
  logic [31:0] query_pc;
  logic        commit_valid, commit_is_branch, commit_taken, commit_mispredict;
  logic [31:0] commit_pc, commit_target;

  logic        p0_valid, p0_taken, p1_valid, p1_taken;
  logic [31:0] p0_target, p1_target, s0_br, s0_mis, s1_br, s1_mis;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk_in = ~clk_in;

  branch_predictor_gshare #(.IDX_BITS(6), .HIST_BITS(4), .TAG_BITS(8), .MODE(0)) dut0 (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .query_valid(query_valid), .query_pc(query_pc), .flush(flush),
    .pred_valid(p0_valid), .pred_taken(p0_taken), .pred_target(p0_target),
    .commit_valid(commit_valid), .commit_is_branch(commit_is_branch),
    .commit_pc(commit_pc), .commit_taken(commit_taken),
    .commit_target(commit_target), .commit_mispredict(commit_mispredict),
    .stat_branches(s0_br), .stat_mispredicts(s0_mis)
  );

  branch_predictor_gshare #(.IDX_BITS(6), .HIST_BITS(4), .TAG_BITS(8), .MODE(1)) dut1 (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .query_valid(query_valid), .query_pc(query_pc), .flush(flush),
    .pred_valid(p1_valid), .pred_taken(p1_taken), .pred_target(p1_target),
    .commit_valid(commit_valid), .commit_is_branch(commit_is_branch),
    .commit_pc(commit_pc), .commit_taken(commit_taken),
    .commit_target(commit_target), .commit_mispredict(commit_mispredict),
    .stat_branches(s1_br), .stat_mispredicts(s1_mis)
  );

  typedef struct {
    logic        rst, rdy, qv;
    logic [31:0] qpc;
    logic        fl, cv, cib;
    logic [31:0] cpc;
    logic        ct;
    logic [31:0] ctgt;
    logic        cm;
    logic        ev, et;
    logic [31:0] etgt, eb, em;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t row(input int rst, input int rdy, input int qv, input logic [31:0] qpc,
                               input int fl, input int cv, input int cib, input logic [31:0] cpc,
                               input int ct, input logic [31:0] ctgt, input int cm,
                               input int ev, input int et, input logic [31:0] etgt,
                               input logic [31:0] eb, input logic [31:0] em);
    vec_t r;
    r.rst = (rst != 0); r.rdy = (rdy != 0); r.qv = (qv != 0); r.qpc = qpc;
    r.fl = (fl != 0); r.cv = (cv != 0); r.cib = (cib != 0); r.cpc = cpc;
    r.ct = (ct != 0); r.ctgt = ctgt; r.cm = (cm != 0);
    r.ev = (ev != 0); r.et = (et != 0); r.etgt = etgt; r.eb = eb; r.em = em;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic rst, input logic rdy, input logic qv, input logic [31:0] qpc,
                     input logic fl, input logic cv, input logic cib, input logic [31:0] cpc,
                     input logic ct, input logic [31:0] ctgt, input logic cm);
    rst_in = rst; rdy_in = rdy; query_valid = qv; query_pc = qpc; flush = fl;
    commit_valid = cv; commit_is_branch = cib; commit_pc = cpc;
    commit_taken = ct; commit_target = ctgt; commit_mispredict = cm;
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic commit(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                        input logic mis, input logic fl);
    cyc(1'b0, 1'b1, 1'b0, 32'h0, fl, 1'b1, 1'b1, pc, taken, tgt, mis);
  endtask

  initial begin
    // Rows are for the MODE 0 instance; PCs 0x100 and 0x200 share index 0 with tags 0x01/0x02.
    //              rst rdy qv qpc          fl cv cib cpc       ct ctgt       cm  ev et etgt          eb  em
    tbl.push_back(row(1, 1, 1, 32'h100,      0, 0, 0, 32'h0,    0, 32'h0,    0,  0, 0, 32'h0,        0,  0));
    tbl.push_back(row(0, 1, 1, 32'h100,      0, 0, 0, 32'h0,    0, 32'h0,    0,  1, 0, 32'h104,      0,  0));
    tbl.push_back(row(0, 1, 1, 32'hFFFFFFFC, 0, 0, 0, 32'h0,    0, 32'h0,    0,  1, 0, 32'h0,        0,  0));
    tbl.push_back(row(0, 1, 0, 32'h0,        0, 0, 0, 32'h0,    0, 32'h0,    0,  0, 0, 32'h0,        0,  0));
    tbl.push_back(row(0, 1, 0, 32'h0,        0, 1, 1, 32'h100,  1, 32'h80,   1,  0, 0, 32'h0,        1,  1));
    tbl.push_back(row(0, 1, 0, 32'h0,        0, 1, 1, 32'h100,  1, 32'h80,   0,  0, 0, 32'h0,        2,  1));
    tbl.push_back(row(0, 1, 1, 32'h100,      0, 0, 0, 32'h0,    0, 32'h0,    0,  1, 1, 32'h80,       2,  1));
    tbl.push_back(row(0, 1, 1, 32'h200,      0, 0, 0, 32'h0,    0, 32'h0,    0,  1, 0, 32'h204,      2,  1));
    tbl.push_back(row(0, 1, 1, 32'h100,      1, 0, 0, 32'h0,    0, 32'h0,    0,  0, 0, 32'h0,        2,  1));
    tbl.push_back(row(0, 1, 1, 32'h100,      0, 0, 0, 32'h0,    0, 32'h0,    0,  1, 1, 32'h80,       2,  1));
    tbl.push_back(row(0, 0, 1, 32'h100,      0, 1, 1, 32'h100,  0, 32'h0,    1,  1, 1, 32'h80,       2,  1));
    tbl.push_back(row(0, 0, 1, 32'h100,      0, 1, 1, 32'h100,  0, 32'h0,    1,  1, 1, 32'h80,       2,  1));
    tbl.push_back(row(0, 0, 1, 32'h100,      0, 1, 1, 32'h100,  0, 32'h0,    1,  1, 1, 32'h80,       2,  1));
    tbl.push_back(row(0, 1, 0, 32'h0,        0, 1, 1, 32'h100,  0, 32'h0,    0,  0, 0, 32'h0,        3,  1));
    tbl.push_back(row(0, 1, 1, 32'h100,      0, 0, 0, 32'h0,    0, 32'h0,    0,  1, 1, 32'h80,       3,  1));
    tbl.push_back(row(0, 1, 0, 32'h0,        0, 1, 0, 32'h100,  0, 32'h0,    1,  0, 0, 32'h0,        3,  1));
    tbl.push_back(row(0, 1, 1, 32'h100,      0, 0, 0, 32'h0,    0, 32'h0,    0,  1, 1, 32'h80,       3,  1));
    tbl.push_back(row(0, 1, 0, 32'h0,        0, 1, 1, 32'h100,  0, 32'h0,    1,  0, 0, 32'h0,        4,  2));
    tbl.push_back(row(0, 1, 0, 32'h0,        0, 1, 1, 32'h100,  0, 32'h0,    0,  0, 0, 32'h0,        5,  2));
    tbl.push_back(row(0, 1, 1, 32'h100,      0, 0, 0, 32'h0,    0, 32'h0,    0,  1, 0, 32'h104,      5,  2));
    tbl.push_back(row(0, 1, 0, 32'h0,        0, 1, 1, 32'h100,  0, 32'h0,    0,  0, 0, 32'h0,        6,  2));
    tbl.push_back(row(0, 1, 1, 32'h100,      0, 0, 0, 32'h0,    0, 32'h0,    0,  1, 0, 32'h104,      6,  2));
    tbl.push_back(row(1, 1, 1, 32'h100,      0, 1, 1, 32'h100,  1, 32'h80,   1,  0, 0, 32'h0,        0,  0));
    tbl.push_back(row(0, 1, 1, 32'h100,      0, 0, 0, 32'h0,    0, 32'h0,    0,  1, 0, 32'h104,      0,  0));
    tbl.push_back(row(0, 1, 0, 32'h0,        0, 1, 1, 32'h200,  1, 32'h900,  0,  0, 0, 32'h0,        1,  0));
    tbl.push_back(row(0, 1, 1, 32'h200,      0, 1, 1, 32'h200,  1, 32'hA00,  1,  1, 1, 32'h900,      2,  1));
    tbl.push_back(row(0, 1, 1, 32'h200,      0, 0, 0, 32'h0,    0, 32'h0,    0,  1, 1, 32'hA00,      2,  1));
    tbl.push_back(row(0, 1, 1, 32'h100,      0, 0, 0, 32'h0,    0, 32'h0,    0,  1, 0, 32'h104,      2,  1));
    tbl.push_back(row(0, 1, 0, 32'h0,        0, 1, 1, 32'h200,  1, 32'hA00,  0,  0, 0, 32'h0,        3,  1));
    tbl.push_back(row(0, 1, 0, 32'h0,        0, 1, 1, 32'h200,  0, 32'hBBB,  0,  0, 0, 32'h0,        4,  1));
    tbl.push_back(row(0, 1, 1, 32'h200,      0, 0, 0, 32'h0,    0, 32'h0,    0,  1, 1, 32'hA00,      4,  1));
    tbl.push_back(row(0, 1, 0, 32'h0,        0, 1, 1, 32'h200,  0, 32'h0,    0,  0, 0, 32'h0,        5,  1));
    tbl.push_back(row(0, 1, 1, 32'h200,      0, 0, 0, 32'h0,    0, 32'h0,    0,  1, 0, 32'h204,      5,  1));

    cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    foreach (tbl[i]) begin
      cyc(tbl[i].rst, tbl[i].rdy, tbl[i].qv, tbl[i].qpc, tbl[i].fl, tbl[i].cv,
          tbl[i].cib, tbl[i].cpc, tbl[i].ct, tbl[i].ctgt, tbl[i].cm);
      chk($sformatf("row%0d pred_valid", i), 32'(p0_valid), 32'(tbl[i].ev));
      if (tbl[i].ev || tbl[i].rst) begin
        chk($sformatf("row%0d pred_taken", i), 32'(p0_taken), 32'(tbl[i].et));
        chk($sformatf("row%0d pred_target", i), p0_target, tbl[i].etgt);
      end
      chk($sformatf("row%0d stat_branches", i), s0_br, tbl[i].eb);
      chk($sformatf("row%0d stat_mispredicts", i), s0_mis, tbl[i].em);
    end

    // Global history: T,T,N,T on PC 0x100 (index 0) from reset.
    cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    commit(32'h100, 1'b1, 32'h80, 1'b0, 1'b0);
    commit(32'h100, 1'b1, 32'h80, 1'b0, 1'b0);
    commit(32'h100, 1'b0, 32'h80, 1'b0, 1'b0);
    commit(32'h100, 1'b1, 32'h80, 1'b0, 1'b0);
    chk("ghr after TTNT", 32'(dut1.ghr), 32'hD);
    // Next update on PC 0x10 (ib 4) lands at 4 ^ 4'b1101 = 9; flush alongside must not matter.
    commit(32'h10, 1'b1, 32'h4444, 1'b0, 1'b1);
    chk("gshare pht[9] trained", 32'(dut1.pht[9]), 32'h2);
    chk("gshare pht[4] untouched", 32'(dut1.pht[4]), 32'h1);
    chk("ghr after 5th update", 32'(dut1.ghr), 32'hB);
    chk("bimodal pht[4] trained", 32'(dut0.pht[4]), 32'h2);
    // Query 0x10: gshare uses index 4 ^ 4'b1011 = 15 (counter 01), bimodal uses index 4 (counter 10).
    cyc(1'b0, 1'b1, 1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("gshare query taken", 32'(p1_taken), 32'h0);
    chk("gshare query target", p1_target, 32'h14);
    chk("bimodal query taken", 32'(p0_taken), 32'h1);
    chk("bimodal query target", p0_target, 32'h4444);
    idle();
    chk("pred_valid single cycle", 32'(p1_valid), 32'h0);

    // Misprediction counter wrap.
    cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    force dut0.stat_mis_q = 32'hFFFF_FFFF;
    #1;
    release dut0.stat_mis_q;
    idle();
    chk("mispredicts preload held", s0_mis, 32'hFFFF_FFFF);
    commit(32'h300, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("mispredicts wrap", s0_mis, 32'h0);
    chk("branches after wrap", s0_br, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
